gpio_pad_cfg_ctrl: RTL and testbench
====================================

Name: gpio_pad_cfg_ctrl

Overview:
- Runtime configuration controller for the openframe GPIO pad bank. Receives 16-bit serial frames on three dedicated gpio_in pins, stages per-pad configuration in shadow registers, and applies all pads atomically on a commit frame.
- Drives the wrapper's gpio_dm0/1/2, gpio_oeb, gpio_inp_dis, gpio_slow_sel, gpio_vtrip_sel and gpio_ib_mode_sel buses. Sits beside the user design inside openframe_project_wrapper.

Parameters:
- NUM_PADS, 44, number of pads configured (max 254).
- SYNC_STAGES, 2, flop stages on each serial input (min 2).
- RESET_CFG, 8'h30, per-pad config byte at reset: dm=001 (input), oeb=1, all other fields 0.

Ports:
- clk  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- cfg_sclk  input  1  serial clock, asynchronous to clk.
- cfg_csb  input  1  frame select, active-low, asynchronous.
- cfg_sdi  input  1  serial data, MSB first, sampled on cfg_sclk rising.
- cfg_sdo  output  1  readback data (see Optional Feature).
- cfg_commit  output  1  one-cycle pulse when shadow is copied to active.
- cfg_err  output  1  sticky error flag.
- gpio_dm0/gpio_dm1/gpio_dm2  output  NUM_PADS each  drive-mode bits 0/1/2, per pad.
- gpio_oeb, gpio_inp_dis, gpio_slow_sel, gpio_vtrip_sel, gpio_ib_mode_sel  output  NUM_PADS each  per-pad pad controls.

Behaviour:
- Clock and reset: one clock, clk; reset resetb is asynchronous and active-low.
- Config byte layout: [7:5] dm[2:0], [4] oeb, [3] inp_dis, [2] slow_sel, [1] vtrip_sel, [0] ib_mode_sel.
- Reset values: shadow and active registers = RESET_CFG for every pad; cfg_commit=0, cfg_err=0, cfg_sdo=0; FSM in IDLE. Reset mid-frame discards the partial frame.
- Input conditioning: cfg_sclk, cfg_csb and cfg_sdi each pass through SYNC_STAGES flops.
  - A sclk rise is a synced sclk of 1 that was 0 on the previous cycle.
  - The sdi value used is the synced sdi in that same cycle.
- Frame format: 16 bits, [15:8] addr, [7:0] data.
- FSM:
  - IDLE -> ADDR when synced csb=0.
  - ADDR: shift 8 bits, then -> DATA.
  - DATA: shift 8 bits; on the 16th rise -> EXEC.
  - EXEC: one cycle, action below, then -> DONE.
  - DONE: wait for csb=1, then -> IDLE.
  - csb=1 in ADDR or DATA: partial frame discarded, cfg_err set, -> IDLE.
  - Extra sclk rises in DONE are ignored and set cfg_err.
  - csb rise and sclk rise in the same synced cycle: csb wins, the edge is ignored.
- EXEC actions:
  - addr < NUM_PADS: shadow[addr] <= data. Active registers unchanged.
  - addr = 8'hFF, data = 8'hA5: all active <= all shadow in one cycle; cfg_commit pulses on the following cycle.
  - addr = 8'hFF, any other data: no action, cfg_err set.
  - addr = 8'hFE: cfg_err cleared (data ignored).
  - Any other addr: cfg_err set, no register change.
- Latency: gpio_* outputs change 1 cycle after EXEC of a commit, i.e. SYNC_STAGES+2 clk cycles after the 16th sclk rise arrives at the pin.
- gpio_* outputs are registered directly from active registers. There are no glitches between commits.
- Timing requirement: the clk period must be shorter than one quarter of the cfg_sclk period.

Optional Feature:
- Macro: GPIO_PAD_CFG_READBACK_EN.
- With the macro: when ADDR completes with addr < NUM_PADS, the active byte for that pad loads into an 8-bit output shifter.
  - cfg_sdo presents its MSB.
  - The shifter advances 1 cycle after each sclk rise in DATA, giving 8 bits MSB first.
  - For an out-of-range addr, cfg_sdo stays 0.
- Without the macro: cfg_sdo is tied 0 and the shifter is absent.

Decomposition:
- Package gpio_pad_cfg_pkg holds:
  - cfg byte field offsets;
  - ADDR_COMMIT=8'hFF, COMMIT_KEY=8'hA5, ADDR_ERRCLR=8'hFE;
  - the FSM state enum (IDLE, ADDR, DATA, EXEC, DONE).
- One sub-module: gpio_pad_cfg_sync, a parameterised SYNC_STAGES synchroniser plus rising-edge detector, instantiated for sclk, csb and sdi.

Test Plan:
- Reset: after resetb release, every pad reads dm=001, oeb=1, other fields 0; cfg_err=0 and cfg_sdo=0.
- Write frame 16'h05_C0 then commit 16'hFF_A5 -> pad 5 dm=110, oeb=0; all other pads unchanged; cfg_commit high exactly 1 cycle.
- Write 16'h05_C0 without a commit -> gpio outputs unchanged; a later commit applies the value.
- csb released after 10 bits -> no register change, cfg_err=1. Then frame 16'hFE_00 -> cfg_err=0.
- Frame 16'h2C_12 (addr 44) -> cfg_err=1, no write. Frame 16'hFF_00 -> no commit, cfg_err=1.
- With GPIO_PAD_CFG_READBACK_EN: commit pad 3 = 8'h9B, then frame 16'h03_00 -> cfg_sdo shifts out 1,0,0,1,1,0,1,1.

Source files
------------

// File: rtl/gpio_pad_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration controller.
package gpio_pad_cfg_pkg;

    // Config byte field offsets: [7:5] dm, [4] oeb, [3] inp_dis, [2] slow, [1] vtrip, [0] ib_mode
    localparam int CFG_DM2     = 7;
    localparam int CFG_DM1     = 6;
    localparam int CFG_DM0     = 5;
    localparam int CFG_OEB     = 4;
    localparam int CFG_INP_DIS = 3;
    localparam int CFG_SLOW    = 2;
    localparam int CFG_VTRIP   = 1;
    localparam int CFG_IB_MODE = 0;

    localparam logic [7:0] ADDR_COMMIT = 8'hFF;
    localparam logic [7:0] COMMIT_KEY  = 8'hA5;
    localparam logic [7:0] ADDR_ERRCLR = 8'hFE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        EXEC = 3'd3,
        DONE = 3'd4
    } cfg_state_e;

endpackage

// File: rtl/gpio_pad_cfg_sync.sv
// Multi-flop synchroniser with rising-edge detect on the synchronised value.
module gpio_pad_cfg_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the synchroniser chain and keep last synced value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/gpio_pad_cfg_ctrl.sv
// GPIO pad bank configuration controller: serial frames stage per-pad
// config bytes into shadow registers; a keyed commit frame copies all
// shadow bytes to the active registers that drive the pad buses.
// Optional readback shifter enabled by GPIO_PAD_CFG_READBACK_EN.
module gpio_pad_cfg_ctrl
    import gpio_pad_cfg_pkg::*;
#(
    parameter int         NUM_PADS    = 44,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_CFG   = 8'h30
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                cfg_sclk,
    input  logic                cfg_csb,
    input  logic                cfg_sdi,
    output logic                cfg_sdo,
    output logic                cfg_commit,
    output logic                cfg_err,
    output logic [NUM_PADS-1:0] gpio_dm0,
    output logic [NUM_PADS-1:0] gpio_dm1,
    output logic [NUM_PADS-1:0] gpio_dm2,
    output logic [NUM_PADS-1:0] gpio_oeb,
    output logic [NUM_PADS-1:0] gpio_inp_dis,
    output logic [NUM_PADS-1:0] gpio_slow_sel,
    output logic [NUM_PADS-1:0] gpio_vtrip_sel,
    output logic [NUM_PADS-1:0] gpio_ib_mode_sel
);

    localparam logic [7:0] NPADS = 8'(NUM_PADS);

    logic sclk_s, sclk_rise, csb_s, sdi_s;
    logic csb_rise_unused, sdi_rise_unused, sync_unused;

    gpio_pad_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(resetb), .d_i(cfg_sclk), .q_o(sclk_s), .rise_o(sclk_rise));
    gpio_pad_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst_n(resetb), .d_i(cfg_csb), .q_o(csb_s), .rise_o(csb_rise_unused));
    gpio_pad_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(resetb), .d_i(cfg_sdi), .q_o(sdi_s), .rise_o(sdi_rise_unused));

    assign sync_unused = sclk_s ^ csb_rise_unused ^ sdi_rise_unused;

    cfg_state_e                state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [15:0]               sh_q, sh_d;
    logic                      err_q, commit_q;
    logic [NUM_PADS-1:0][7:0]  shadow_q, active_q;
    logic                      exec_wr, exec_commit, err_set, err_clr;

    // Frame FSM state register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    // Next-state, bit shifting and EXEC decode; csb release is checked before sclk
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        exec_wr     = 1'b0;
        exec_commit = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!csb_s) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end
            end
            ADDR, DATA: begin
                if (csb_s) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end else if (sclk_rise) begin
                    sh_d  = {sh_q[14:0], sdi_s};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7)  state_d = DATA;
                    if (cnt_q == 4'd15) state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                if (sh_q[15:8] < NPADS) begin
                    exec_wr = 1'b1;
                end else if (sh_q[15:8] == ADDR_COMMIT) begin
                    if (sh_q[7:0] == COMMIT_KEY) exec_commit = 1'b1;
                    else                         err_set     = 1'b1;
                end else if (sh_q[15:8] == ADDR_ERRCLR) begin
                    err_clr = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            DONE: begin
                if (csb_s)          state_d = IDLE;
                else if (sclk_rise) err_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow write, atomic commit, sticky error and commit pulse
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow_q[i] <= RESET_CFG;
                active_q[i] <= RESET_CFG;
            end
            err_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (exec_wr && sh_q[15:8] == 8'(i)) shadow_q[i] <= sh_q[7:0];
            end
            if (exec_commit) active_q <= shadow_q;
            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            commit_q <= exec_commit;
        end
    end

    assign cfg_commit = commit_q;
    assign cfg_err    = err_q;

    // Pad buses come straight from the active flops so they only move on commit
    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        assign gpio_dm0[i]         = active_q[i][CFG_DM0];
        assign gpio_dm1[i]         = active_q[i][CFG_DM1];
        assign gpio_dm2[i]         = active_q[i][CFG_DM2];
        assign gpio_oeb[i]         = active_q[i][CFG_OEB];
        assign gpio_inp_dis[i]     = active_q[i][CFG_INP_DIS];
        assign gpio_slow_sel[i]    = active_q[i][CFG_SLOW];
        assign gpio_vtrip_sel[i]   = active_q[i][CFG_VTRIP];
        assign gpio_ib_mode_sel[i] = active_q[i][CFG_IB_MODE];
    end

`ifdef GPIO_PAD_CFG_READBACK_EN
    logic [7:0] rb_q, rb_byte, rb_addr;
    logic       rb_load, rb_shift;

    assign rb_addr  = {sh_q[6:0], sdi_s};
    assign rb_load  = (state_q == ADDR) && !csb_s && sclk_rise && (cnt_q == 4'd7);
    assign rb_shift = (state_q == DATA) && !csb_s && sclk_rise;

    // Select the addressed pad's active byte; out-of-range addresses read as 0
    always_comb begin
        rb_byte = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (rb_addr == 8'(i)) rb_byte = active_q[i];
        end
    end

    // Readback shifter: load at end of address, shift once per data bit
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)       rb_q <= '0;
        else if (rb_load)  rb_q <= rb_byte;
        else if (rb_shift) rb_q <= {rb_q[6:0], 1'b0};
    end

    assign cfg_sdo = rb_q[7];
`else
    assign cfg_sdo = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pad_cfg_ctrl.sv
// Directed bench for gpio_pad_cfg_ctrl: frames are bit-banged on the
// serial pins and pad buses are compared with a hand-maintained table.
module tb_gpio_pad_cfg_ctrl;

    localparam int N = 44;

    logic clk = 1'b0, resetb = 1'b0;
    logic cfg_sclk = 1'b0, cfg_csb = 1'b1, cfg_sdi = 1'b0;
    logic cfg_sdo, cfg_commit, cfg_err;
    logic [N-1:0] gpio_dm0, gpio_dm1, gpio_dm2, gpio_oeb, gpio_inp_dis;
    logic [N-1:0] gpio_slow_sel, gpio_vtrip_sel, gpio_ib_mode_sel;

    int n_cmp = 0, n_mis = 0;
    int commit_cycles = 0;
    logic [7:0] exp_act [N];
    logic [7:0] rd;

    gpio_pad_cfg_ctrl #(.NUM_PADS(N), .SYNC_STAGES(2), .RESET_CFG(8'h30)) dut (
        .clk(clk), .resetb(resetb), .cfg_sclk(cfg_sclk), .cfg_csb(cfg_csb),
        .cfg_sdi(cfg_sdi), .cfg_sdo(cfg_sdo), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
        .gpio_dm0(gpio_dm0), .gpio_dm1(gpio_dm1), .gpio_dm2(gpio_dm2),
        .gpio_oeb(gpio_oeb), .gpio_inp_dis(gpio_inp_dis), .gpio_slow_sel(gpio_slow_sel),
        .gpio_vtrip_sel(gpio_vtrip_sel), .gpio_ib_mode_sel(gpio_ib_mode_sel));

    always #5 clk = ~clk;

    always @(posedge clk) if (cfg_commit) commit_cycles++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pads(input string tag);
        logic [7:0][N-1:0] e;
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 8; b++) e[b][i] = exp_act[i][b];
        chk({tag, "_dm0"},   64'(gpio_dm0),         64'(e[5]));
        chk({tag, "_dm1"},   64'(gpio_dm1),         64'(e[6]));
        chk({tag, "_dm2"},   64'(gpio_dm2),         64'(e[7]));
        chk({tag, "_oeb"},   64'(gpio_oeb),         64'(e[4]));
        chk({tag, "_inpd"},  64'(gpio_inp_dis),     64'(e[3]));
        chk({tag, "_slow"},  64'(gpio_slow_sel),    64'(e[2]));
        chk({tag, "_vtrip"}, 64'(gpio_vtrip_sel),   64'(e[1]));
        chk({tag, "_ib"},    64'(gpio_ib_mode_sel), 64'(e[0]));
    endtask

    // Sends the first nbits of f MSB first (bits past 16 are zeros);
    // samples cfg_sdo just before each data-phase rise into rd.
    task automatic send(input logic [15:0] f, input int nbits, output logic [7:0] rdo);
        rdo = '0;
        cfg_csb = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            cfg_sdi = (i < 16) ? f[15-i] : 1'b0;
            if (i >= 8 && i < 16) rdo[15-i] = cfg_sdo;
            #50 cfg_sclk = 1'b1;
            #50 cfg_sclk = 1'b0;
        end
        #100 cfg_csb = 1'b1;
        #200;
    endtask

    initial begin
        for (int i = 0; i < N; i++) exp_act[i] = 8'h30;
        #100 resetb = 1'b1;
        #100;
        chk_pads("reset");
        chk("reset_err", 64'(cfg_err), 64'd0);
        chk("reset_sdo", 64'(cfg_sdo), 64'd0);
        chk("reset_commit", 64'(commit_cycles), 64'd0);

        // stage pad 5 only: outputs must hold
        send(16'h05C0, 16, rd);
        chk_pads("staged");
        chk("staged_err", 64'(cfg_err), 64'd0);
        chk("staged_commit", 64'(commit_cycles), 64'd0);

        // commit: pad 5 -> dm=110, oeb=0; pulse exactly one cycle
        send(16'hFFA5, 16, rd);
        exp_act[5] = 8'hC0;
        chk_pads("commit1");
        chk("commit1_pulse", 64'(commit_cycles), 64'd1);
        chk("commit1_err", 64'(cfg_err), 64'd0);

        // pad 7 staged, held until the later commit
        send(16'h071F, 16, rd);
        chk_pads("stage7");
        send(16'hFFA5, 16, rd);
        exp_act[7] = 8'h1F;
        chk_pads("commit7");
        chk("commit7_pulse", 64'(commit_cycles), 64'd2);

        // aborted after 10 bits: error, nothing staged
        send(16'h0AFF, 10, rd);
        chk("abort_err", 64'(cfg_err), 64'd1);
        send(16'hFFA5, 16, rd);
        chk_pads("abort");
        chk("abort_pulse", 64'(commit_cycles), 64'd3);
        send(16'hFE00, 16, rd);
        chk("errclr", 64'(cfg_err), 64'd0);

        // address 44 is out of range
        send(16'h2C12, 16, rd);
        chk("oor_err", 64'(cfg_err), 64'd1);
        send(16'hFFA5, 16, rd);
        chk_pads("oor");
        send(16'hFE00, 16, rd);
        chk("errclr2", 64'(cfg_err), 64'd0);

        // bad commit key
        send(16'hFF00, 16, rd);
        chk("badkey_err", 64'(cfg_err), 64'd1);
        chk("badkey_pulse", 64'(commit_cycles), 64'd4);
        send(16'hFE00, 16, rd);
        chk("errclr3", 64'(cfg_err), 64'd0);

        // 17th rise lands in DONE: error even though the frame cleared it
        send(16'hFE00, 17, rd);
        chk("extra_err", 64'(cfg_err), 64'd1);
        send(16'hFE00, 16, rd);

        // readback of pad 3
        send(16'h039B, 16, rd);
        send(16'hFFA5, 16, rd);
        exp_act[3] = 8'h9B;
        chk_pads("commit3");
        send(16'h0300, 16, rd);
`ifdef GPIO_PAD_CFG_READBACK_EN
        chk("readback", 64'(rd), 64'h9B);
`else
        chk("readback_off", 64'(rd), 64'h00);
`endif
        send(16'h2C00, 16, rd);
        chk("readback_oor", 64'(rd), 64'h00);
        chk("final_err", 64'(cfg_err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
